// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared types, limits and the load-extend helper for dmem_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package dmem_pkg;

  localparam int MAX_WAIT_CYCLES = 15;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } state_e;

  // The unused 2'b11 encoding is folded onto word.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input size_e       sz,
                                              input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: return {{24{~is_unsigned & b[7]}}, b};
      SZ_HALF: return {{16{~is_unsigned & h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// dmem_lane_align : byte-enable / write-lane replication and load extraction.
// Optional macro  : DMEM_MISALIGN_TRAP_EN (flag and suppress misaligned ops)
// Revision        : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    misalign   = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
    rdata_ext = load_extend(rword, addr_lo, size, is_unsigned);
`ifdef DMEM_MISALIGN_TRAP_EN
    case (size)
      SZ_HALF: misalign = addr_lo[0];
      SZ_WORD: misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
    // A trapped access must neither write nor return data.
    if (misalign) begin
      byte_en   = 4'b0000;
      rdata_ext = 32'h0;
    end
`else
    misalign = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl : handshaked byte/half/word data memory with wait states and a
//             post-reset clear sequencer.
// Optional macro : DMEM_MISALIGN_TRAP_EN
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2     = 10,
  parameter int ADDR_W         = 16,
  parameter int WAIT_CYCLES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         DEPTH       = 2 ** DEPTH_LOG2;
  localparam logic [3:0] WAIT_LAST   = 4'(WAIT_CYCLES - 1);
  localparam state_e     RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  logic [31:0] mem_array [DEPTH];

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DEPTH_LOG2+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;

  logic                  cur_we;
  logic [1:0]            cur_size;
  logic                  cur_uns;
  logic [DEPTH_LOG2+1:0] cur_addr;
  logic [31:0]           cur_wdata;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [31:0]           rd_word;

  logic [3:0]            byte_en;
  logic [31:0]           wdata_lane;
  logic [31:0]           rdata_ext;
  logic                  misalign;

  logic                  accept;
  logic                  go;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wd;
  logic [DEPTH_LOG2-1:0] mem_idx;

  generate
    if (ADDR_W > DEPTH_LOG2 + 2) begin : g_addr_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_LOG2+2];
    end
  endgenerate

  // With zero wait states the access happens on the acceptance edge, so the
  // live request is used in IDLE and the latched copy everywhere else.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we    = req_we;
      cur_size  = req_size;
      cur_uns   = req_unsigned;
      cur_addr  = req_addr[DEPTH_LOG2+1:0];
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign cur_idx = cur_addr[DEPTH_LOG2+1:2];
  assign rd_word = mem_array[cur_idx];
  assign accept  = req_valid && req_ready_q;

  dmem_lane_align u_align (
    .size        (decode_size(cur_size)),
    .addr_lo     (cur_addr[1:0]),
    .is_unsigned (cur_uns),
    .wdata       (cur_wdata),
    .rword       (rd_word),
    .byte_en     (byte_en),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    go          = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'b0000;
    mem_wd      = 32'h0;
    mem_idx     = cur_idx;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = 4'b1111;
        mem_idx   = clr_idx_q;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == {DEPTH_LOG2{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          we_d       = req_we;
          size_d     = req_size;
          uns_d      = req_unsigned;
          addr_d     = req_addr[DEPTH_LOG2+1:0];
          wdata_d    = req_wdata;
          wait_cnt_d = 4'd0;
          if (WAIT_CYCLES == 0) begin
            go = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          go = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (go) begin
      state_d     = ST_ACCESS;
      rsp_valid_d = 1'b1;
      rsp_err_d   = misalign;
      rsp_rdata_d = (cur_we || misalign) ? 32'h0 : rdata_ext;
      if (cur_we) begin
        mem_we = 1'b1;
        mem_be = byte_en;
        mem_wd = wdata_lane;
      end
    end

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      clr_idx_q   <= '0;
      wait_cnt_q  <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Reset suppresses any write, including one whose request was just accepted.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_array[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// tb_dmem_ctrl : directed bench for dmem_ctrl (DEPTH_LOG2=4, WAIT_CYCLES=2)
// Revision     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  dmem_ctrl #(
    .DEPTH_LOG2     (4),
    .ADDR_W         (16),
    .WAIT_CYCLES    (2),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Counts cycles with busy high after reset release; no rsp_valid may appear.
  task automatic wait_clear(input string tag);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 16);
    chk({tag, "_no_rsp"}, {31'h0, seen}, 32'h0);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [15:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e, input string tag);
    int n;
    int lim;
    lim = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid !== 1'b1 && n < 20);
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_rdata"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_e});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_hold"}, rsp_rdata, exp_d);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 16'h0;
    req_wdata    = 32'h0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    wait_clear("clear1");

    req(1'b0, 2'b10, 1'b0, 16'h003C, 32'h0, 32'h0000_0000, 1'b0, "lw_3c");
    req(1'b1, 2'b10, 1'b0, 16'h0008, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_08");
    req(1'b0, 2'b10, 1'b0, 16'h0008, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_08");
`ifdef DMEM_MISALIGN_TRAP_EN
    req(1'b0, 2'b10, 1'b0, 16'h0009, 32'h0, 32'h0000_0000, 1'b1, "lw_09_mis");
    req(1'b1, 2'b10, 1'b0, 16'h0009, 32'h1111_1111, 32'h0, 1'b1, "sw_09_mis");
`else
    req(1'b0, 2'b10, 1'b0, 16'h0009, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_09_mis");
    req(1'b1, 2'b10, 1'b0, 16'h000B, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_0b_mis");
`endif
    req(1'b0, 2'b10, 1'b0, 16'h0008, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_08_again");

    req(1'b1, 2'b00, 1'b0, 16'h000A, 32'h0000_0080, 32'h0, 1'b0, "sb_0a");
    req(1'b0, 2'b00, 1'b0, 16'h000A, 32'h0, 32'hFFFF_FF80, 1'b0, "lb_0a");
    req(1'b0, 2'b00, 1'b1, 16'h000A, 32'h0, 32'h0000_0080, 1'b0, "lbu_0a");
    req(1'b0, 2'b10, 1'b0, 16'h0008, 32'h0, 32'hDE80_BEEF, 1'b0, "lw_08_sb");
    req(1'b0, 2'b11, 1'b1, 16'h0008, 32'h0, 32'hDE80_BEEF, 1'b0, "lw_08_sz11");
    req(1'b0, 2'b00, 1'b0, 16'h0009, 32'h0, 32'hFFFF_FFBE, 1'b0, "lb_09");

    req(1'b1, 2'b01, 1'b0, 16'h000E, 32'h0000_8001, 32'h0, 1'b0, "sh_0e");
    req(1'b0, 2'b01, 1'b0, 16'h000E, 32'h0, 32'hFFFF_8001, 1'b0, "lh_0e");
    req(1'b0, 2'b01, 1'b1, 16'h000E, 32'h0, 32'h0000_8001, 1'b0, "lhu_0e");
    req(1'b0, 2'b10, 1'b0, 16'h000C, 32'h0, 32'h8001_0000, 1'b0, "lw_0c");
    req(1'b0, 2'b10, 1'b0, 16'h004C, 32'h0, 32'h8001_0000, 1'b0, "lw_4c_alias");
    req(1'b0, 2'b01, 1'b1, 16'h000C, 32'h0, 32'h0000_0000, 1'b0, "lhu_0c");

    // Store accepted, then reset lands while it is waiting.
    @(negedge clk);
    req_we       = 1'b1;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 16'h0010;
    req_wdata    = 32'h1234_5678;
    req_valid    = 1'b1;
    chk("sw_10_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst2_busy", {31'h0, busy}, 32'h1);
    chk("rst2_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    wait_clear("clear2");
    req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'h0000_0000, 1'b0, "lw_10_after_rst");
    req(1'b0, 2'b10, 1'b0, 16'h0008, 32'h0, 32'h0000_0000, 1'b0, "lw_08_cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller for the pipelined MIPS core. It replaces the flat word-only store with a request/response handshake and byte/half/word loads and stores. Loads are sign- or zero-extended, and the wait-state count is configurable. After reset the array is cleared one word per cycle by a sequencer, not in zero time. It sits in the MEM stage, and the pipeline stalls while req_ready is low.

Parameters:
DEPTH_LOG2, 10, log2 of number of 32-bit words; array is 2**DEPTH_LOG2 words.
ADDR_W, 16, width of byte address; must be >= DEPTH_LOG2+2.
WAIT_CYCLES, 0, extra cycles between acceptance and array access (0..15).
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip clear, contents undefined.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
req_addr  in  ADDR_W  byte address, little-endian.
req_wdata  in  32  store data, right-justified.
rsp_valid  out  1  one-cycle completion pulse, for loads and stores.
rsp_rdata  out  32  load result; 0 for stores.
rsp_err  out  1  misaligned access flag, qualified by rsp_valid.
busy  out  1  high during reset and clear sequence.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1, state=CLEAR (IDLE if CLEAR_ON_RESET=0), clear index=0, wait counter=0.
- FSM states: CLEAR, IDLE, WAIT, ACCESS.
  - CLEAR: writes word[idx]=0 and increments idx each cycle. At idx=2**DEPTH_LOG2-1 it goes to IDLE and busy falls. Duration is exactly 2**DEPTH_LOG2 cycles after rst deasserts.
  - IDLE: req_ready=1. Handshake is req_valid&&req_ready at a rising edge. On it, all req_* are latched and the FSM goes to WAIT, or to ACCESS if WAIT_CYCLES=0.
  - WAIT: counts WAIT_CYCLES cycles, then goes to ACCESS.
  - ACCESS: performs the array write or read at this edge, pulses rsp_valid with rsp_rdata/rsp_err, and returns to IDLE.
- Latency: rsp_valid is high in the cycle WAIT_CYCLES+1 cycles after the acceptance cycle.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- req_* are ignored when req_ready=0; the latched copies are used.
- Word index is addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses alias modulo the array size.
- Store byte: writes lane addr[1:0] with wdata[7:0]; other lanes unchanged.
- Store half: writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
- Store word: writes all four lanes.
- Loads: the selected byte or half is extracted and extended per req_unsigned. Word loads ignore req_unsigned.
- rsp_rdata holds its value until the next rsp_valid. rsp_valid is low otherwise.
- rst in any state: returns to the reset state the next cycle. A pending store is discarded (no array write), and no rsp_valid pulse is produced.
- A request accepted and reset in the same cycle is dropped.

Optional Feature:
DMEM_MISALIGN_TRAP_EN.
- Defined: a half with addr[0]=1, or a word with addr[1:0]!=00, is misaligned. Such a request performs no write, returns rsp_rdata=0, and pulses rsp_err=1 with rsp_valid. Timing is unchanged.
- Undefined: the low address bits are ignored for alignment (half uses addr[1], word uses neither), and rsp_err is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum for sizes (SZ_BYTE, SZ_HALF, SZ_WORD);
  - typedef enum for FSM states;
  - the load-extend function;
  - localparam for maximum WAIT_CYCLES.
- One sub-module, dmem_lane_align: purely combinational. It produces the 4-bit byte-enable and lane-replicated write data from size/addr/wdata, and the extracted, extended load data from the read word. The controller keeps the FSM, counters and array.

Test Plan:
All scenarios use DEPTH_LOG2=4, WAIT_CYCLES=2.
1. rst high 1 cycle -> busy high, req_ready low for 16 cycles, then req_ready=1; LW 0x3C -> rdata 0x00000000.
2. SW 0x08 0xDEADBEEF, then LW 0x08 -> rsp_valid exactly 3 cycles after each acceptance; rdata 0xDEADBEEF; the store reports rdata 0.
3. After (2): SB 0x0A 0x00000080 -> LB 0x0A = 0xFFFFFF80, LBU 0x0A = 0x00000080, LW 0x08 = 0xDE80BEEF.
4. SH 0x0E 0x00008001 -> LH 0x0E = 0xFFFF8001, LHU 0x0E = 0x00008001, LW 0x0C = 0x80010000. LW 0x4C (aliasing) = 0x80010000.
5. SW 0x10 0x12345678 with rst asserted in WAIT -> no rsp_valid; after clear, LW 0x10 = 0.
6. LW 0x09 after (2): with DMEM_MISALIGN_TRAP_EN -> rsp_err=1, rdata 0; without -> rsp_err=0, rdata 0xDEADBEEF.
